// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: shared screen geometry, coordinate width, scheduler state encoding and LFSR taps.
package game_pkg;

  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [COORD_W-1:0] UNDEFINED_POSITION = 11'd1000;

  // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } sched_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/object_scheduler_if.sv
`default_nettype none
// object_scheduler_if: renderer-facing read port and legacy object_position bus.
interface object_scheduler_if
  import game_pkg::*;
#(
  parameter int N_OBJ = 4
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [COORD_W-1:0] object_position;

  modport master (output rd_idx, input rd_valid, rd_x, rd_y, object_position);
  modport slave  (input rd_idx, output rd_valid, rd_x, rd_y, object_position);

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// lfsr16: free-running 16-bit Galois LFSR, advances every clock out of reset.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SEED;
    else          state <= lfsr_next(state);
  end

endmodule
`default_nettype wire

// File: rtl/object_scheduler.sv
`default_nettype none
// object_scheduler: per-frame spawn/move/retire/collision sweep over the falling-object table.
// Optional: define SCORE_EN to build the saturating 16-bit dodge counter on the score port.
module object_scheduler
  import game_pkg::*;
#(
  parameter int          N_OBJ        = 4,
  parameter int          OBJ_W        = 50,
  parameter int          OBJ_H        = 22,
  parameter int          SPEED        = 2,
  parameter int          SPAWN_PERIOD = 30,
  parameter int          SCREEN_W     = game_pkg::SCREEN_W,
  parameter int          SCREEN_H     = game_pkg::SCREEN_H,
  parameter int          PLANE_Y      = 430,
  parameter int          PLANE_W      = 40,
  parameter int          LIVES_INIT   = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                v_sync,
  input  logic [COORD_W-1:0]  plane_x,
  object_scheduler_if.slave   rd_bus,
  output logic                hit,
  output logic [1:0]          lives,
  output logic                game_over,
  output logic                busy,
  output logic [15:0]         score
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int TMR_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [COORD_W-1:0] OBJ_W_PX    = COORD_W'(OBJ_W);
  localparam logic [COORD_W-1:0] OBJ_H_PX    = COORD_W'(OBJ_H);
  localparam logic [COORD_W-1:0] SPEED_PX    = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] PLANE_Y_PX  = COORD_W'(PLANE_Y);
  localparam logic [COORD_W-1:0] PLANE_W_PX  = COORD_W'(PLANE_W);
  localparam logic [COORD_W-1:0] SCREEN_H_PX = COORD_W'(SCREEN_H);
  localparam logic [COORD_W-1:0] SPAWN_X_MAX = COORD_W'(SCREEN_W - OBJ_W);
  localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(N_OBJ - 1);
  localparam logic [TMR_W-1:0]   TMR_LAST    = TMR_W'(SPAWN_PERIOD - 1);

  sched_state_t       state;
  logic [IDX_W-1:0]   idx;
  logic               obj_valid [N_OBJ];
  logic [COORD_W-1:0] obj_x     [N_OBJ];
  logic [COORD_W-1:0] obj_y     [N_OBJ];
  logic [TMR_W-1:0]   spawn_timer;
  logic               vs_prev;
  logic [15:0]        lfsr_state;
  logic               unused_lfsr_bits;

  logic               frame_start;
  logic               collide;
  logic               off_screen;
  logic               have_free;
  logic [IDX_W-1:0]   free_idx;
  logic [COORD_W-1:0] y_new;
  logic [COORD_W-1:0] raw_x;
  logic [COORD_W-1:0] spawn_x;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr_state)
  );

  assign unused_lfsr_bits = ^lfsr_state[15:10];

  assign frame_start = vs_prev & ~v_sync;
  assign y_new       = obj_y[idx] + SPEED_PX;
  assign collide     = (y_new + OBJ_H_PX > PLANE_Y_PX)
                    && (obj_x[idx] < plane_x + PLANE_W_PX)
                    && (plane_x < obj_x[idx] + OBJ_W_PX);
  assign off_screen  = (y_new >= SCREEN_H_PX);
  // One conditional subtract folds the 10-bit random value into 0..SCREEN_W-OBJ_W
  assign raw_x       = {1'b0, lfsr_state[9:0]};
  assign spawn_x     = (raw_x > SPAWN_X_MAX) ? (raw_x - SPAWN_X_MAX) : raw_x;

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (!obj_valid[i]) begin
        have_free = 1'b1;
        free_idx  = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      idx                    <= '0;
      spawn_timer            <= '0;
      vs_prev                <= 1'b0;
      hit                    <= 1'b0;
      lives                  <= 2'(LIVES_INIT);
      game_over              <= 1'b0;
      busy                   <= 1'b0;
      rd_bus.object_position <= UNDEFINED_POSITION;
      for (int i = 0; i < N_OBJ; i++) begin
        obj_valid[i] <= 1'b0;
        obj_x[i]     <= '0;
        obj_y[i]     <= '0;
      end
    end else begin
      vs_prev <= v_sync;
      hit     <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start && enable && !game_over) begin
            state <= SCAN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (obj_valid[idx]) begin
            if (collide) begin
              obj_valid[idx] <= 1'b0;
              hit            <= 1'b1;
              if (lives != 2'd0) lives <= lives - 2'd1;
              if (lives <= 2'd1) game_over <= 1'b1;
            end else if (off_screen) begin
              obj_valid[idx] <= 1'b0;
            end else begin
              obj_y[idx] <= y_new;
            end
          end
          if (idx == LAST_IDX) state <= SPAWN;
          else                 idx   <= idx + 1'b1;
        end
        SPAWN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (spawn_timer == TMR_LAST) begin
            spawn_timer <= '0;
            if (have_free) begin
              obj_valid[free_idx]    <= 1'b1;
              obj_x[free_idx]        <= spawn_x;
              obj_y[free_idx]        <= '0;
              rd_bus.object_position <= spawn_x;
            end
          end else begin
            spawn_timer <= spawn_timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_bus.rd_valid <= 1'b0;
      rd_bus.rd_x     <= '0;
      rd_bus.rd_y     <= '0;
    end else begin
      rd_bus.rd_valid <= obj_valid[rd_bus.rd_idx];
      rd_bus.rd_x     <= obj_x[rd_bus.rd_idx];
      rd_bus.rd_y     <= obj_y[rd_bus.rd_idx];
    end
  end

`ifdef SCORE_EN
  logic [15:0] score_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_cnt <= '0;
    end else if (state == SCAN && obj_valid[idx] && !collide && off_screen
                 && score_cnt != 16'hFFFF) begin
      score_cnt <= score_cnt + 16'd1;
    end
  end

  assign score = score_cnt;
`else
  assign score = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_object_scheduler.sv
`default_nettype none
// tb_object_scheduler: directed frame-level stimulus for object_scheduler with a small table model.
module tb_object_scheduler;

`ifdef SCORE_EN
  localparam int SCORE_ON = 1;
`else
  localparam int SCORE_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        v_sync;
  logic [10:0] plane_x;
  logic        hit;
  logic [1:0]  lives;
  logic        game_over;
  logic        busy;
  logic [15:0] score;

  object_scheduler_if #(.N_OBJ(4)) bus ();

  object_scheduler dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .v_sync    (v_sync),
    .plane_x   (plane_x),
    .rd_bus    (bus),
    .hit       (hit),
    .lives     (lives),
    .game_over (game_over),
    .busy      (busy),
    .score     (score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_cnt  = 0;
  int busy_cnt = 0;

  logic [15:0] m_lfsr;
  bit          m_valid [4];
  int          m_x     [4];
  int          m_y     [4];
  int          m_timer, m_lives, m_score, m_pos;
  bit          m_go;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  always @(negedge clk) begin
    if (hit === 1'b1)  hit_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_x[i]     = 0;
      m_y[i]     = 0;
    end
    m_timer = 0;
    m_lives = 3;
    m_score = 0;
    m_pos   = 1000;
    m_go    = 1'b0;
  endtask

  task automatic model_frame(input logic [15:0] lf);
    int  yn;
    int  sx;
    bit  found;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) begin
        yn = m_y[i] + 2;
        if (yn + 22 > 430 && m_x[i] < plane_x + 40 && plane_x < m_x[i] + 50) begin
          m_valid[i] = 1'b0;
          if (m_lives > 0) m_lives--;
          if (m_lives == 0) m_go = 1'b1;
        end else if (yn >= 480) begin
          m_valid[i] = 1'b0;
          m_score++;
        end else begin
          m_y[i] = yn;
        end
      end
    end
    if (m_timer == 29) begin
      m_timer = 0;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && !m_valid[i]) begin
          found = 1'b1;
          sx = int'(lf[9:0]);
          if (sx > 590) sx -= 590;
          m_valid[i] = 1'b1;
          m_x[i]     = sx;
          m_y[i]     = 0;
          m_pos      = sx;
        end
      end
    end else begin
      m_timer++;
    end
  endtask

  // A sweep starts at the edge after v_sync falls; the spawn uses the LFSR value of the 6th cycle.
  task automatic do_frame();
    logic [15:0] spawn_lfsr;
    @(negedge clk) v_sync = 1'b0;
    repeat (5) @(posedge clk);
    #1 spawn_lfsr = m_lfsr;
    @(posedge clk);
    @(negedge clk) v_sync = 1'b1;
    repeat (2) @(negedge clk);
    if (enable && !m_go) model_frame(spawn_lfsr);
  endtask

  task automatic read_slot(input int i, output logic v, output logic [10:0] x, output logic [10:0] y);
    @(negedge clk) bus.rd_idx = 2'(i);
    @(negedge clk);
    v = bus.rd_valid;
    x = bus.rd_x;
    y = bus.rd_y;
  endtask

  task automatic check_table(input string tag);
    logic        v;
    logic [10:0] x, y;
    for (int i = 0; i < 4; i++) begin
      read_slot(i, v, x, y);
      check_eq($sformatf("%s_slot%0d_valid", tag, i), v, m_valid[i]);
      if (m_valid[i]) begin
        check_eq($sformatf("%s_slot%0d_x", tag, i), x, m_x[i]);
        check_eq($sformatf("%s_slot%0d_y", tag, i), y, m_y[i]);
      end
    end
    check_eq($sformatf("%s_pos", tag), bus.object_position, m_pos);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        v;
    logic [10:0] x, y;
    int          b0, h0, guard, pos_prev;

    reset_n    = 1'b0;
    enable     = 1'b1;
    v_sync     = 1'b1;
    plane_x    = 11'd1000;
    bus.rd_idx = '0;
    model_reset();
    repeat (3) @(negedge clk);

    check_eq("rst_busy", busy, 0);
    check_eq("rst_hit", hit, 0);
    check_eq("rst_lives", lives, 3);
    check_eq("rst_game_over", game_over, 0);
    check_eq("rst_pos", bus.object_position, 1000);
    check_eq("rst_score", score, 0);
    check_eq("rst_rd_valid", bus.rd_valid, 0);
    check_eq("rst_rd_x", bus.rd_x, 0);
    check_eq("rst_rd_y", bus.rd_y, 0);

    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    b0 = busy_cnt;
    enable = 1'b0;
    do_frame();
    check_eq("frozen_busy", busy_cnt - b0, 0);
    enable = 1'b1;

    b0 = busy_cnt;
    do_frame();
    check_eq("sweep_busy_cycles", busy_cnt - b0, 5);

    repeat (28) do_frame();
    check_eq("pre_spawn_pos", bus.object_position, 1000);
    read_slot(0, v, x, y);
    check_eq("pre_spawn_valid", v, 0);

    do_frame();
    read_slot(0, v, x, y);
    check_eq("spawn_valid", v, 1);
    check_eq("spawn_y", y, 0);
    check_eq("spawn_x", x, m_x[0]);
    check_eq("spawn_pos", bus.object_position, m_x[0]);
    check_eq("spawn_in_range", bus.object_position <= 11'd590, 1);

    do_frame();
    read_slot(0, v, x, y);
    check_eq("move_y2", y, 2);

    repeat (118) do_frame();
    pos_prev = m_pos;
    do_frame();
    check_eq("full_drop_pos", bus.object_position, pos_prev);
    read_slot(0, v, x, y);
    check_eq("full_slot0_y", y, 240);
    check_table("full");

    repeat (119) do_frame();
    read_slot(0, v, x, y);
    check_eq("pre_retire_y", y, 478);
    check_eq("pre_retire_score", score, 0);

    do_frame();
    check_eq("retire_score", score, SCORE_ON);
    check_eq("no_hits_offplane", hit_cnt, 0);
    read_slot(0, v, x, y);
    check_eq("respawn_y", y, 0);
    check_table("respawn");

    // Reset lands while slot 2 is being scanned
    @(negedge clk) v_sync = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pos", bus.object_position, 1000);
    check_eq("midrst_lives", lives, 3);
    check_eq("midrst_rd_valid", bus.rd_valid, 0);
    check_eq("midrst_score", score, 0);
    @(negedge clk);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b0 = busy_cnt;
    repeat (6) @(negedge clk);
    check_eq("post_rst_no_sweep", busy_cnt - b0, 0);
    read_slot(0, v, x, y);
    check_eq("post_rst_slot0", v, 0);
    v_sync = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      guard = 0;
      while (!(m_valid[t] && m_y[t] == 406) && guard < 400) begin
        do_frame();
        guard++;
      end
      check_eq($sformatf("reach_406_t%0d", t), guard < 400, 1);
      plane_x = 11'(m_x[t]);
      h0 = hit_cnt;
      do_frame();
      check_eq($sformatf("edge408_hits_t%0d", t), hit_cnt - h0, 0);
      check_eq($sformatf("edge408_lives_t%0d", t), lives, 3 - t);
      do_frame();
      check_eq($sformatf("hit_pulse_t%0d", t), hit_cnt - h0, 1);
      check_eq($sformatf("hit_lives_t%0d", t), lives, 2 - t);
      read_slot(t, v, x, y);
      check_eq($sformatf("hit_slot_t%0d", t), v, 0);
      plane_x = 11'd1000;
    end
    check_eq("game_over_set", game_over, 1);

    b0 = busy_cnt;
    repeat (3) do_frame();
    check_eq("go_no_sweep", busy_cnt - b0, 0);
    check_eq("go_lives", lives, 0);
    check_table("go_hold");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
